// File: rtl/pe_pkg.sv
// Shared constants and state encoding for the processing-element accumulator.
package pe_pkg;

    localparam int PE_PROD_W = 32;
    localparam int PE_ACC_W  = 40;
    localparam int PE_CNT_W  = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } pe_acc_state_t;

endpackage

// File: rtl/pe_acc_add.sv
// ACC_W-bit unsigned adder for the accumulator; wraps by default and clamps at
// all-ones when PE_ACC_SATURATE_EN is defined (then also reports the clamp).
module pe_acc_add
    import pe_pkg::*;
#(
    parameter int ACC_W = PE_ACC_W
) (
    input  logic [ACC_W-1:0] a,
    input  logic [ACC_W-1:0] b,
    output logic [ACC_W-1:0] sum
`ifdef PE_ACC_SATURATE_EN
    ,
    output logic             clamp
`endif
);

`ifdef PE_ACC_SATURATE_EN
    // Result packs {clamped, value}; a carry out means the true sum exceeded all-ones.
    function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] x,
                                               input logic [ACC_W-1:0] y);
        logic [ACC_W:0] full;
        full = {1'b0, x} + {1'b0, y};
        if (full[ACC_W])
            return {1'b1, {ACC_W{1'b1}}};
        return {1'b0, full[ACC_W-1:0]};
    endfunction

    assign {clamp, sum} = sat_add(a, b);
`else
    function automatic logic [ACC_W-1:0] wrap_add(input logic [ACC_W-1:0] x,
                                                  input logic [ACC_W-1:0] y);
        return x + y;
    endfunction

    assign sum = wrap_add(a, b);
`endif

endmodule

// File: rtl/pe_accumulator.sv
// Dot-product accumulator behind the PE multiplier: sums len products, holds the
// result under valid/ready. Optional clamping arithmetic via PE_ACC_SATURATE_EN.
module pe_accumulator
    import pe_pkg::*;
#(
    parameter int PROD_W = PE_PROD_W,
    parameter int ACC_W  = PE_ACC_W,
    parameter int CNT_W  = PE_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CNT_W-1:0]  len,
    input  logic [PROD_W-1:0] prod,
    input  logic              prod_valid,
    output logic              busy,
    output logic [ACC_W-1:0]  acc_out,
    output logic              out_valid,
    input  logic              out_ready,
`ifdef PE_ACC_SATURATE_EN
    output logic              sat,
`endif
    output logic              overrun
);

    pe_acc_state_t    state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] sum;
    logic             fire;
    logic             last;
    logic             start_ok;

    assign prod_ext = ACC_W'(prod);
    assign fire     = prod_valid && (state == ACCUM);
    assign last     = fire && (cnt == CNT_W'(1));
    assign start_ok = start && (len != '0);

`ifdef PE_ACC_SATURATE_EN
    logic clamp;
    logic sat_run;

    pe_acc_add #(.ACC_W(ACC_W)) u_add (
        .a     (acc),
        .b     (prod_ext),
        .sum   (sum),
        .clamp (clamp)
    );
`else
    pe_acc_add #(.ACC_W(ACC_W)) u_add (
        .a   (acc),
        .b   (prod_ext),
        .sum (sum)
    );
`endif

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // A start coinciding with the final product re-arms immediately (no bubble).
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_ok) state_nxt = ACCUM;
            ACCUM:   if (last)     state_nxt = start_ok ? ACCUM : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == ACCUM);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            acc <= '0;
        end else if (state == IDLE) begin
            if (start_ok) begin
                cnt <= len;
                acc <= '0;
            end
        end else if (last) begin
            cnt <= start_ok ? len : '0;
            acc <= '0;
        end else if (fire) begin
            cnt <= cnt - CNT_W'(1);
            acc <= sum;
        end
    end

    // Completion outranks a handshake in the same cycle: the new value simply replaces the taken one.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_out   <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else if (last) begin
            acc_out   <= sum;
            out_valid <= 1'b1;
            if (out_valid && !out_ready)
                overrun <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef PE_ACC_SATURATE_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            sat_run <= 1'b0;
            sat     <= 1'b0;
        end else begin
            if (last) begin
                sat     <= sat_run | clamp;
                sat_run <= 1'b0;
            end else if (fire) begin
                sat_run <= sat_run | clamp;
            end else if (state == IDLE && start_ok) begin
                sat_run <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pe_accumulator.sv
// Bench for pe_accumulator: directed scenarios plus randomized traffic, all
// compared every cycle against a transaction-level reference model.
module tb_pe_accumulator;

    localparam int PROD_W = 32;
    localparam int ACC_W  = 33;
    localparam int CNT_W  = 8;
    localparam logic [63:0] MAXV = (64'd1 << ACC_W) - 64'd1;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [CNT_W-1:0]  len;
    logic [PROD_W-1:0] prod;
    logic              prod_valid;
    logic              busy;
    logic [ACC_W-1:0]  acc_out;
    logic              out_valid;
    logic              out_ready;
    logic              overrun;
`ifdef PE_ACC_SATURATE_EN
    logic              sat;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: the products collected so far for the open dot product.
    bit                m_busy;
    int                m_len;
    logic [PROD_W-1:0] m_terms[$];
    logic [63:0]       m_out;
    bit                m_ov;
    bit                m_ovr;
    bit                m_sat;

    pe_accumulator #(.PROD_W(PROD_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .len        (len),
        .prod       (prod),
        .prod_valid (prod_valid),
        .busy       (busy),
        .acc_out    (acc_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
`ifdef PE_ACC_SATURATE_EN
        .sat        (sat),
`endif
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Sum of a finished dot product under wrap or clamp rules.
    task automatic dot_sum(output logic [63:0] s, output bit clamped);
        s = 64'd0;
        clamped = 1'b0;
        foreach (m_terms[i]) begin
            s = s + 64'(m_terms[i]);
            if (s > MAXV) begin
`ifdef PE_ACC_SATURATE_EN
                s = MAXV;
                clamped = 1'b1;
`else
                s = s & MAXV;
`endif
            end
        end
    endtask

    task automatic model_step();
        bit          fin;
        logic [63:0] s;
        bit          cl;
        fin = 1'b0;
        s = 64'd0;
        cl = 1'b0;
        if (reset) begin
            m_busy = 1'b0; m_len = 0; m_terms.delete();
            m_out = 64'd0; m_ov = 1'b0; m_ovr = 1'b0; m_sat = 1'b0;
            return;
        end
        if (m_busy && prod_valid) begin
            m_terms.push_back(prod);
            if (m_terms.size() == m_len) begin
                fin = 1'b1;
                dot_sum(s, cl);
            end
        end
        if (fin) begin
            if (m_ov && !out_ready) m_ovr = 1'b1;
            m_out = s;
            m_ov  = 1'b1;
            m_sat = cl;
        end else if (m_ov && out_ready) begin
            m_ov = 1'b0;
        end
        if ((!m_busy || fin) && start && len != 0) begin
            m_busy = 1'b1;
            m_len  = int'(len);
            m_terms.delete();
        end else if (fin) begin
            m_busy = 1'b0;
        end
    endtask

    // One clock: model consumes the pre-edge inputs, outputs compared 1 time unit later.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("busy", 64'(busy), 64'(m_busy));
        check("out_valid", 64'(out_valid), 64'(m_ov));
        check("acc_out", 64'(acc_out), m_out);
        check("overrun", 64'(overrun), 64'(m_ovr));
`ifdef PE_ACC_SATURATE_EN
        check("sat", 64'(sat), 64'(m_sat));
`endif
    endtask

    task automatic drive(input bit st, input int ln, input bit pv, input logic [31:0] p);
        start      = st;
        len        = CNT_W'(ln);
        prod_valid = pv;
        prod       = p;
    endtask

    initial begin
        reset = 1'b1; out_ready = 1'b1;
        drive(0, 0, 0, 0);
        m_busy = 0; m_len = 0; m_out = 0; m_ov = 0; m_ovr = 0; m_sat = 0;
        tick(); tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_acc_out", 64'(acc_out), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);
        reset = 1'b0;

        // Basic sum with gaps between products
        drive(1, 3, 0, 0);   tick(); check("basic_busy", 64'(busy), 64'd1);
        drive(0, 0, 1, 10);  tick();
        drive(0, 0, 0, 0);   tick();
        drive(0, 0, 1, 20);  tick();
        drive(0, 0, 0, 0);   tick();
        drive(0, 0, 1, 30);  tick();
        check("basic_sum", 64'(acc_out), 64'd60);
        check("basic_valid", 64'(out_valid), 64'd1);
        check("basic_busy_fall", 64'(busy), 64'd0);
        drive(0, 0, 0, 0);   tick(); check("basic_valid_1cyc", 64'(out_valid), 64'd0);

        // Back-to-back with restart on the final product
        drive(1, 2, 0, 0);             tick();
        drive(0, 0, 1, 32'hFFFF_FFFF); tick();
        drive(1, 1, 1, 32'hFFFF_FFFF); tick();
        check("b2b_first", 64'(acc_out), 64'h1_FFFF_FFFE);
        check("b2b_busy", 64'(busy), 64'd1);
        drive(0, 0, 1, 5);             tick();
        check("b2b_second", 64'(acc_out), 64'd5);
        check("b2b_valid", 64'(out_valid), 64'd1);
        drive(0, 0, 0, 0);             tick();

        // Backpressure and overrun
        out_ready = 1'b0;
        drive(1, 1, 0, 0); tick();
        drive(0, 0, 1, 7); tick();
        drive(1, 1, 0, 0); tick();
        drive(0, 0, 1, 9); tick();
        check("ovr_acc", 64'(acc_out), 64'd9);
        check("ovr_valid", 64'(out_valid), 64'd1);
        check("ovr_flag", 64'(overrun), 64'd1);
        out_ready = 1'b1;
        drive(0, 0, 0, 0); tick();
        check("ovr_drain", 64'(out_valid), 64'd0);
        check("ovr_sticky", 64'(overrun), 64'd1);

        // Wrap / saturation at ACC_W=33
        drive(1, 3, 0, 0);             tick();
        drive(0, 0, 1, 32'hFFFF_FFFF); tick();
        tick();
        tick();
`ifdef PE_ACC_SATURATE_EN
        check("sat_acc", 64'(acc_out), 64'h1_FFFF_FFFF);
        check("sat_flag", 64'(sat), 64'd1);
`else
        check("wrap_acc", 64'(acc_out), 64'h0_FFFF_FFFD);
`endif
        drive(0, 0, 0, 0); tick();

        // Illegal length and idle products
        drive(1, 0, 0, 0);   tick();
        check("len0_busy", 64'(busy), 64'd0);
        drive(0, 0, 0, 0);   tick();
        check("len0_valid", 64'(out_valid), 64'd0);
        drive(0, 0, 1, 100); tick();
        drive(1, 1, 0, 0);   tick();
        drive(0, 0, 1, 4);   tick();
        check("idle_ignore", 64'(acc_out), 64'd4);
        drive(0, 0, 0, 0);   tick();

        // Reset mid-operation
        drive(1, 4, 0, 0); tick();
        drive(0, 0, 1, 1); tick();
        drive(0, 0, 1, 2); tick();
        reset = 1'b1; drive(0, 0, 0, 0); tick();
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_acc", 64'(acc_out), 64'd0);
        check("midrst_ovr", 64'(overrun), 64'd0);
        reset = 1'b0;
        drive(1, 1, 0, 0); tick();
        drive(0, 0, 1, 3); tick();
        check("midrst_after", 64'(acc_out), 64'd3);
        drive(0, 0, 0, 0); tick();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] p;
            p = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
            reset     = ($urandom_range(0, 199) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            drive($urandom_range(0, 3) == 0,
                  ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 5)),
                  $urandom_range(0, 1) == 1, p);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pe_accumulator.md
Name: pe_accumulator

Overview:
- Downstream consumer of the 16x16 pipelined multiplier inside one systolic-array processing element.
- Takes each 32-bit product qualified by the multiplier's done strobe and sums a programmed count of products into one dot-product term.
- Holds the finished sum in an output register under a valid/ready handshake until the array drain logic takes it.
- Supports back-to-back dot products with no bubble.

Parameters:
- PROD_W, 32: product width; must equal the multiplier result width.
- ACC_W, 40: accumulator and result width; must be >= PROD_W.
- CNT_W, 8: width of the product-count field; maximum length is 2^CNT_W-1.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a dot product; samples len.
- len  in  CNT_W  number of products to accumulate; 0 is illegal and ignored.
- prod  in  PROD_W  unsigned product from the multiplier.
- prod_valid  in  1  multiplier done strobe; prod is valid when high.
- busy  out  1  high while accumulating.
- acc_out  out  ACC_W  completed dot-product sum.
- out_valid  out  1  acc_out holds an unconsumed result.
- out_ready  in  1  downstream accepts acc_out when out_valid && out_ready.
- overrun  out  1  sticky; set when an unconsumed result is overwritten.

Behaviour:
- Reset values (at every posedge with reset high, including mid-operation): state=IDLE, acc=0, cnt=0, acc_out=0, out_valid=0, busy=0, overrun=0. Any in-flight accumulation is abandoned.
- State machine, two states:
  - IDLE: start && len!=0 -> ACCUM, with cnt<=len, acc<=0, busy<=1. start with len==0 is ignored and no result is produced. prod_valid is ignored in IDLE.
  - ACCUM: each prod_valid does acc<=acc+zext(prod) and cnt<=cnt-1. start is ignored except in the final-product cycle (see below).
- Final product: prod_valid && cnt==1.
  - acc_out<=acc+zext(prod), out_valid<=1.
  - State goes to IDLE, busy<=0, acc<=0.
  - Latency: out_valid rises one cycle after the final prod_valid.
- Start in the same cycle as the final product:
  - The result is emitted as above.
  - The state stays in ACCUM with cnt<=len and acc<=0 (back-to-back, zero bubble).
  - If len==0 in that cycle, the state goes to IDLE.
- Output handshake:
  - out_valid && out_ready with no completion in that cycle -> out_valid<=0; acc_out keeps its last value.
  - Completion while out_valid && !out_ready -> acc_out overwritten, out_valid stays 1, overrun<=1 (sticky until reset).
  - Completion in the same cycle as out_valid && out_ready -> new value loaded, out_valid stays 1, no overrun.
- Arithmetic:
  - Unsigned. prod is zero-extended to ACC_W.
  - Without the optional feature, the sum wraps modulo 2^ACC_W.
- The block never back-pressures the multiplier; it has no ready output toward it.

Optional Feature:
- Macro: PE_ACC_SATURATE_EN.
- Defined:
  - Each addition clamps at 2^ACC_W-1.
  - Adds an output sat (1 bit), valid with acc_out, set when any addition in that dot product clamped.
  - sat is cleared at start and by reset.
- Undefined: wrap-around arithmetic and no sat port.

Decomposition:
- Shared package pe_pkg holds:
  - PROD_W, ACC_W and CNT_W default constants.
  - The state enum pe_acc_state_t {IDLE, ACCUM}.
- One natural sub-module: pe_acc_add (ACC_W adder, saturating under PE_ACC_SATURATE_EN). The control FSM stays in the top module.

Test Plan:
- Basic sum: reset; start len=3; prods 10, 20, 30 on non-consecutive cycles, out_ready=1 -> out_valid for exactly 1 cycle, acc_out=60, busy falls with the last product.
- Back-to-back:
  - start len=2; products 0xFFFF_FFFF, 0xFFFF_FFFF.
  - A second start len=1 arrives on the cycle of the second product, then product 5.
  - Result 0x1_FFFF_FFFE, then result 5, with no bubble.
- Backpressure and overrun:
  - out_ready=0; complete two length-1 dot products (7 then 9).
  - -> acc_out=9, out_valid=1, overrun=1.
  - Then out_ready=1 -> out_valid=0, overrun remains 1.
- Wrap/saturation:
  - Setup: ACC_W=33; len=3; three products 0xFFFF_FFFF.
  - Without macro: acc_out=0x0_FFFF_FFFD (mod 2^33).
  - With PE_ACC_SATURATE_EN: acc_out=0x1_FFFF_FFFF, sat=1.
- Illegal and idle inputs:
  - start len=0 -> no out_valid, busy stays 0.
  - prod_valid in IDLE -> ignored; the next len=1 dot product of 4 gives 4.
- Reset mid-operation: start len=4; 2 products; reset 1 cycle -> all outputs 0; start len=1 with prod 3 -> acc_out=3.
